// File: rtl/fifo_rd_packer.sv
// Read-side packer: pops entries from an async FIFO and packs RATIO of them per output word.
// Partial words leave on an explicit flush or after TIMEOUT idle cycles, tagged with their entry count.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                              clk_read,
  input  logic                              rst,
  input  logic                              fifo_empty,
  input  logic [DATA_WIDTH-1:0]             fifo_data,
  output logic                              fifo_read,
  input  logic                              flush,
  output logic [DATA_WIDTH*RATIO-1:0]       out_data,
  output logic [$clog2(RATIO):0]            out_count,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy
);

  localparam int CW = $clog2(RATIO) + 1;
  localparam int WW = DATA_WIDTH * RATIO;

  typedef enum logic {ST_FILL, ST_FLUSH} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [WW-1:0]   r_out_data;
  logic [CW-1:0]   r_out_count;
  logic            r_out_valid;
  logic            w_full;
  logic            w_load;
  logic            w_pop;
  logic            w_hit;
  logic [WW-1:0]   w_masked;

  // State register
  always_ff @(posedge clk_read or posedge rst) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; flush is ignored once already flushing
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL:  if (flush || w_hit) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_load || r_cnt == '0) w_state_nxt = ST_FILL;
      default:  w_state_nxt = ST_FILL;
    endcase
  end

  // Output / control logic
  always_comb begin
    w_full    = (r_cnt == CW'(RATIO));
    w_load    = (!r_out_valid || out_ready) &&
                (w_full || (r_state == ST_FLUSH && r_cnt != '0));
    w_pop     = !fifo_empty && r_state == ST_FILL && (!w_full || w_load);
    fifo_read = w_pop;
    busy      = (r_cnt != '0) || r_out_valid || (r_state == ST_FLUSH);
    for (int i = 0; i < RATIO; i++)
      w_masked[i*DATA_WIDTH +: DATA_WIDTH] =
        (CW'(i) < r_cnt) ? r_acc[i*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  // Accumulator: a pop in the same cycle as a load starts the next word in slot 0
  always_ff @(posedge clk_read or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_load) begin
      if (w_pop) begin
        r_acc <= WW'(fifo_data);
        r_cnt <= CW'(1);
      end else begin
        r_acc <= '0;
        r_cnt <= '0;
      end
    end else if (w_pop) begin
      for (int i = 0; i < RATIO; i++)
        if (r_cnt == CW'(i)) r_acc[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_read or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_masked;
      r_out_count <= r_cnt;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_valid = r_out_valid;

  generate
    if (TIMEOUT > 0) begin : g_timer
      localparam int TW = $clog2(TIMEOUT + 1);
      logic [TW-1:0] r_timer;

      // The edge that would reach TIMEOUT switches to FLUSH instead
      assign w_hit = (r_state == ST_FILL) && (r_cnt != '0) && fifo_empty &&
                     (r_timer == TW'(TIMEOUT - 1));

      always_ff @(posedge clk_read or posedge rst) begin
        if (rst)
          r_timer <= '0;
        else if (w_pop || r_cnt == '0 || r_state == ST_FLUSH || w_hit)
          r_timer <= '0;
        else if (fifo_empty)
          r_timer <= r_timer + 1'b1;
      end
    end else begin : g_no_timer
      assign w_hit = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a FIFO model feeds the main instance; a second
// instance built with TIMEOUT=0 is driven directly.
module tb_fifo_rd_packer;

  logic        clk_read = 1'b0;
  logic        rst = 1'b1;
  always #5 clk_read = ~clk_read;

  // FIFO model for the main instance
  logic [7:0]  mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_read;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr];

  always @(posedge clk_read)
    if (fifo_read && !fifo_empty) rd_ptr <= rd_ptr + 1;

  fifo_rd_packer #(.DATA_WIDTH(8), .RATIO(4), .TIMEOUT(16)) u_dut (
    .clk_read(clk_read), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .flush(flush), .out_data(out_data), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  // Timeout-disabled instance
  logic        f0_empty = 1'b1;
  logic [7:0]  f0_data = 8'h00;
  logic        f0_read;
  logic        flush0 = 1'b0;
  logic [31:0] od0;
  logic [2:0]  oc0;
  logic        ov0;
  logic        ordy0 = 1'b1;
  logic        busy0;

  fifo_rd_packer #(.DATA_WIDTH(8), .RATIO(4), .TIMEOUT(0)) u_dut0 (
    .clk_read(clk_read), .rst(rst), .fifo_empty(f0_empty), .fifo_data(f0_data),
    .fifo_read(f0_read), .flush(flush0), .out_data(od0), .out_count(oc0),
    .out_valid(ov0), .out_ready(ordy0), .busy(busy0)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] rx_data[$];
  logic [2:0]  rx_cnt[$];

  // Capture each accepted word; the handshake completes at the next rising edge
  always begin
    @(negedge clk_read);
    #2;
    if (out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_cnt.push_back(out_count);
    end
  end

  task automatic tick();
    @(negedge clk_read);
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int k = 0; k < budget && rx_data.size() < n; k++) tick();
  endtask

  task automatic test_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    total++; if (out_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", out_count); end
    total++; if (busy !== 1'b0 || fifo_read !== 1'b0) begin bad++; $display("FAIL reset_busy_read got=%b%b exp=00", busy, fifo_read); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    logic rd[0:13];
    logic ov[0:13];
    int   nrd, first, last, base;
    base = rx_data.size();
    tick();
    out_ready = 1'b1;
    for (int v = 1; v <= 8; v++) push(8'(v));
    for (int i = 0; i < 14; i++) begin
      if (i > 0) tick();
      #2;
      rd[i] = fifo_read;
      ov[i] = out_valid;
    end
    nrd = 0; first = -1; last = -1;
    for (int i = 0; i < 14; i++)
      if (rd[i]) begin nrd++; if (first < 0) first = i; last = i; end
    total++; if (nrd != 8 || first != 0 || last != 7) begin bad++; $display("FAIL stream_reads got n=%0d first=%0d last=%0d exp 8/0/7", nrd, first, last); end
    total++; if (ov[4] !== 1'b0 || ov[5] !== 1'b1) begin bad++; $display("FAIL stream_latency got=%b%b exp=01", ov[4], ov[5]); end
    wait_rx(base + 2, 20);
    total++; if (rx_data.size() != base + 2) begin bad++; $display("FAIL stream_nwords got=%0d exp=%0d", rx_data.size() - base, 2); end
    total++; if (rx_data[base] !== 32'h04030201 || rx_cnt[base] !== 3'd4) begin bad++; $display("FAIL stream_w0 got=%h/%0d exp=04030201/4", rx_data[base], rx_cnt[base]); end
    total++; if (rx_data[base+1] !== 32'h08070605 || rx_cnt[base+1] !== 3'd4) begin bad++; $display("FAIL stream_w1 got=%h/%0d exp=08070605/4", rx_data[base+1], rx_cnt[base+1]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d10;
    int base;
    tick(); tick();
    base = rx_data.size();
    out_ready = 1'b0;
    for (int v = 1; v <= 12; v++) push(8'(v));
    for (int i = 1; i <= 14; i++) begin
      tick();
      #2;
      if (i == 10) d10 = out_data;
    end
    total++; if (out_valid !== 1'b1 || d10 !== 32'h04030201 || out_data !== 32'h04030201 || out_count !== 3'd4) begin bad++; $display("FAIL bp_hold got=%b %h %h/%0d exp=1 04030201", out_valid, d10, out_data, out_count); end
    total++; if (fifo_read !== 1'b0 || (wr_ptr - rd_ptr) != 4) begin bad++; $display("FAIL bp_stall got rd=%b left=%0d exp rd=0 left=4", fifo_read, wr_ptr - rd_ptr); end
    total++; if (rx_data.size() != base) begin bad++; $display("FAIL bp_nohs got=%0d exp=0", rx_data.size() - base); end
    out_ready = 1'b1;
    wait_rx(base + 3, 30);
    total++; if (rx_data.size() != base + 3) begin bad++; $display("FAIL bp_nwords got=%0d exp=3", rx_data.size() - base); end
    total++; if (rx_data[base] !== 32'h04030201 || rx_data[base+1] !== 32'h08070605 || rx_data[base+2] !== 32'h0C0B0A09) begin bad++; $display("FAIL bp_order got=%h %h %h", rx_data[base], rx_data[base+1], rx_data[base+2]); end
  endtask

  task automatic test_flush();
    int base;
    tick(); tick();
    base = rx_data.size();
    push(8'hA1); push(8'hA2); push(8'hA3);
    tick(); tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_rx(base + 1, 10);
    total++; if (rx_data.size() != base + 1) begin bad++; $display("FAIL flush_nwords got=%0d exp=1", rx_data.size() - base); end
    total++; if (rx_data[base] !== 32'h00A3A2A1 || rx_cnt[base] !== 3'd3) begin bad++; $display("FAIL flush_word got=%h/%0d exp=00A3A2A1/3", rx_data[base], rx_cnt[base]); end
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #2;
    total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty_state got busy=%b ov=%b exp 1/0", busy, out_valid); end
    tick();
    #2;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty_back got busy=%b ov=%b exp 0/0", busy, out_valid); end
    total++; if (rx_data.size() != base + 1) begin bad++; $display("FAIL flush_empty_nowords got=%0d exp=1", rx_data.size() - base); end
  endtask

  task automatic test_timeout();
    logic ov[0:20];
    logic [31:0] d19;
    logic [2:0]  c19;
    int base;
    tick(); tick();
    base = rx_data.size();
    push(8'hB1); push(8'hB2);
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) tick();
      #2;
      ov[i] = out_valid;
      if (i == 19) begin d19 = out_data; c19 = out_count; end
    end
    total++; if (ov[18] !== 1'b0 || ov[19] !== 1'b1) begin bad++; $display("FAIL timeout_edge got=%b%b exp=01", ov[18], ov[19]); end
    total++; if (d19 !== 32'h0000B2B1 || c19 !== 3'd2) begin bad++; $display("FAIL timeout_word got=%h/%0d exp=0000B2B1/2", d19, c19); end
    total++; if (rx_data.size() != base + 1) begin bad++; $display("FAIL timeout_nwords got=%0d exp=1", rx_data.size() - base); end
  endtask

  task automatic test_no_timeout();
    int nov;
    tick();
    f0_empty = 1'b0; f0_data = 8'hB1;
    #2;
    total++; if (f0_read !== 1'b1) begin bad++; $display("FAIL nt_read got=%b exp=1", f0_read); end
    tick(); f0_data = 8'hB2;
    tick(); f0_empty = 1'b1;
    nov = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      #2;
      if (ov0) nov++;
    end
    total++; if (nov != 0 || busy0 !== 1'b1) begin bad++; $display("FAIL nt_idle got ov_cycles=%0d busy=%b exp 0/1", nov, busy0); end
    tick(); flush0 = 1'b1;
    tick(); flush0 = 1'b0;
    tick();
    #2;
    total++; if (ov0 !== 1'b1 || od0 !== 32'h0000B2B1 || oc0 !== 3'd2) begin bad++; $display("FAIL nt_flush got=%b %h/%0d exp=1 0000B2B1/2", ov0, od0, oc0); end
    tick();
    #2;
    total++; if (ov0 !== 1'b0 || busy0 !== 1'b0) begin bad++; $display("FAIL nt_done got ov=%b busy=%b exp 0/0", ov0, busy0); end
  endtask

  task automatic test_reset_mid();
    int base;
    tick(); tick();
    out_ready = 1'b0;
    for (int v = 1; v <= 6; v++) push(8'(v));
    for (int i = 0; i < 8; i++) tick();
    #2;
    total++; if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 32'h04030201) begin bad++; $display("FAIL rstmid_pre got ov=%b busy=%b d=%h exp 1/1/04030201", out_valid, busy, out_data); end
    #1 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_count !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_async got ov=%b d=%h c=%0d busy=%b exp 0/0/0/0", out_valid, out_data, out_count, busy); end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    base = rx_data.size();
    tick();
    for (int v = 8'h11; v <= 8'h14; v++) push(8'(v));
    wait_rx(base + 1, 20);
    for (int i = 0; i < 25; i++) tick();
    total++; if (rx_data.size() != base + 1) begin bad++; $display("FAIL rstmid_nwords got=%0d exp=1", rx_data.size() - base); end
    total++; if (rx_data[base] !== 32'h14131211 || rx_cnt[base] !== 3'd4) begin bad++; $display("FAIL rstmid_word got=%h/%0d exp=14131211/4", rx_data[base], rx_cnt[base]); end
  endtask

  task automatic test_flush_full();
    int base;
    tick();
    base = rx_data.size();
    push(8'h21); push(8'h22); push(8'h23);
    tick(); tick(); tick();
    push(8'h24);
    flush = 1'b1;
    #2;
    total++; if (fifo_read !== 1'b1) begin bad++; $display("FAIL ffull_read got=%b exp=1", fifo_read); end
    tick();
    flush = 1'b0;
    wait_rx(base + 1, 10);
    for (int i = 0; i < 20; i++) tick();
    #2;
    total++; if (rx_data.size() != base + 1) begin bad++; $display("FAIL ffull_nwords got=%0d exp=1", rx_data.size() - base); end
    total++; if (rx_data[base] !== 32'h24232221 || rx_cnt[base] !== 3'd4) begin bad++; $display("FAIL ffull_word got=%h/%0d exp=24232221/4", rx_data[base], rx_cnt[base]); end
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL ffull_idle got busy=%b ov=%b exp 0/0", busy, out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_timeout();
    test_no_timeout();
    test_reset_mid();
    test_flush_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
